lzx_cmp_cascade_ctrl: RTL and testbench
=======================================

# lzx_cmp_cascade_ctrl

Sequential driver for the `lzx_74HC85` 4-bit magnitude comparator. It compares two WIDTH-bit operands one nibble per clock through a single external `lzx_74HC85` instance. It owns the comparator's cascade inputs (IA_g/IA_e/IA_l) and feeds the registered cascade outputs (QA_g/QA_e/QA_l) back in, LSB nibble first. It sits between a requesting datapath (start/busy/done handshake) and the comparator, replacing a chain of WIDTH/4 cascaded 74HC85s.

## Interface
- WIDTH, 16, operand width in bits; must be a multiple of 4 and at least 4; NIB = WIDTH/4 nibbles
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous reset, active low
- start  in  1  request; sampled only in IDLE
- a  in  WIDTH  operand A; latched when start is accepted
- b  in  WIDTH  operand B; latched when start is accepted
- busy  out  1  high while a comparison is in progress
- done  out  1  one-cycle pulse; result valid
- gt, eq, lt  out  1 each  registered result, one-hot after the first done; held until the next done
- cmp_a, cmp_b  out  4 each  nibble driven to the comparator's A and B inputs
- ia_g, ia_e, ia_l  out  1 each  cascade inputs driven to the comparator
- qa_g, qa_e, qa_l  in  1 each  comparator outputs, combinational from cmp_a, cmp_b and ia_*
- err  out  1  sticky cascade-protocol error (see Configuration)

## Operation
- Reset values: busy=0, done=0, gt=eq=lt=0, cmp_a=cmp_b=0, ia_g=0, ia_e=1, ia_l=0, err=0, state IDLE, idx=0.
- States:
  - IDLE: if start=1, latch a and b, set idx=0, load cascade register {g,e,l}=3'b010, go to RUN.
  - RUN: drive cmp_a=a_reg[4*idx+:4], cmp_b=b_reg[4*idx+:4] and ia_*=cascade register.
    - Each edge: cascade register <= {qa_g,qa_e,qa_l}.
    - If idx<NIB-1, increment idx.
    - If idx=NIB-1, load gt/eq/lt from {qa_g,qa_e,qa_l}, pulse done, return to IDLE.
- Outside RUN: cmp_a=cmp_b=0 and ia_*=3'b010.
- Nibble order is LSB first, so the MSB nibble decides and equal nibbles pass the lower result upward. This matches parallel 74HC85 cascading.
- The controller always drives one-hot cascade inputs, so the 74HC85 invalid-cascade quirks are never exercised.
- start while busy=1 is ignored. The operands are not re-latched.
- start in the done cycle is accepted, because the state is already IDLE.
- rst_n low mid-run aborts immediately: all outputs take their reset values, and no done pulse is produced.

## Timing
- Start accepted at edge E0. busy=1 from after E0 until after E_NIB.
- Nibble k is on cmp_a/cmp_b during the cycle between E_k and E_k+1. The comparator result for nibble k is captured at E_k+1.
- done=1 and the result becomes valid in the cycle after E_NIB. This is NIB edges after the accepting edge (4 for WIDTH=16).
- Throughput: one comparison per NIB+1 cycles when start is held high.
- qa_* must settle within one clock period. No pipeline stage exists on the combinational loop through the comparator.

## Configuration
- Macro: LZX_CMP_CASCADE_CHECK_EN.
- Defined:
  - In RUN, err is set if {qa_g,qa_e,qa_l} is not one-hot at a capture edge.
  - err stays set until rst_n is asserted.
  - A result is still produced from the raw qa_* values.
- Undefined: err is tied to 0, and no check logic is built.
- The port list is identical in both builds.

## Test plan
All scenarios use WIDTH=16 with a real `lzx_74HC85` instance wired to cmp_*/ia_*/qa_*.
- Reset then idle: all outputs at reset values; ia_e=1; busy=0.
- A=16'h0000, B=16'hFFFF, start pulse -> busy for 4 cycles; done pulse 4 edges after acceptance; lt=1, gt=eq=0.
- A=16'h8000, B=16'h7FFF -> gt=1. A=16'hA5A5, B=16'hA5A5 -> eq=1. A=16'h1235, B=16'h1234 -> gt=1 (LSB decides, upper nibbles equal).
- Start held high for 12 cycles with A=16'h00F0, B=16'h0F00 -> back-to-back done every 5 cycles, lt=1; re-pulsing start while busy does not change the result.
- rst_n dropped for one cycle at idx=2 -> busy=0 and gt/eq/lt=0 immediately; no done pulse; a new start then completes normally.
- Build with LZX_CMP_CASCADE_CHECK_EN, bench model forces qa_*=3'b000 at one capture -> err=1 and stays 1 across later comparisons until reset. Build without the macro, same stimulus -> err=0.

Source files
------------

// File: rtl/lzx_cmp_cascade_ctrl.sv
// rtl/lzx_cmp_cascade_ctrl.sv - nibble-serial driver for one external lzx_74HC85 magnitude comparator
//
// Compares two WIDTH-bit operands one nibble per clock, LSB nibble first. The
// comparator's cascade outputs are registered and fed back as its cascade
// inputs, so one 74HC85 replaces a chain of WIDTH/4 parallel-cascaded parts.
//
// Ports:
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   start, a, b             request and operands (latched when start is accepted in IDLE)
//   busy, done              comparison in progress / one-cycle result-valid pulse
//   gt, eq, lt              registered result, held until the next done
//   cmp_a, cmp_b            nibble presented to the comparator's A/B inputs
//   ia_g, ia_e, ia_l        cascade inputs presented to the comparator
//   qa_g, qa_e, qa_l        comparator outputs (combinational from cmp_* and ia_*)
//   err                     sticky non-one-hot cascade error
//
// Optional build: define LZX_CMP_CASCADE_CHECK_EN to build the cascade check
// behind err; otherwise err is tied to 0. The port list is identical in both builds.

module lzx_cmp_cascade_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             eq,
    output logic             lt,
    output logic [3:0]       cmp_a,
    output logic [3:0]       cmp_b,
    output logic             ia_g,
    output logic             ia_e,
    output logic             ia_l,
    input  logic             qa_g,
    input  logic             qa_e,
    input  logic             qa_l,
    output logic             err
);

    localparam int NIB = WIDTH / 4;
    localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NIB - 1);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [2:0]       casc_q, casc_d;   // {g,e,l} fed back into the comparator
    logic [2:0]       res_q, res_d;     // {gt,eq,lt}
    logic             done_q, done_d;
    logic [2:0]       qa;

    assign qa = {qa_g, qa_e, qa_l};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            casc_q  <= 3'b010;
            res_q   <= 3'b000;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            casc_q  <= casc_d;
            res_q   <= res_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        casc_d  = casc_q;
        res_d   = res_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Operands are only latched here, so start while busy has no effect.
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    idx_d   = '0;
                    casc_d  = 3'b010;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                casc_d = qa;
                if (idx_q == LAST_IDX) begin
                    // MSB nibble has been compared with the lower result cascaded in.
                    res_d   = qa;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy  = (state_q == S_RUN);
        cmp_a = 4'h0;
        cmp_b = 4'h0;
        {ia_g, ia_e, ia_l} = 3'b010;
        if (state_q == S_RUN) begin
            cmp_a = a_q[4*idx_q +: 4];
            cmp_b = b_q[4*idx_q +: 4];
            {ia_g, ia_e, ia_l} = casc_q;
        end
    end

    assign done = done_q;
    assign gt   = res_q[2];
    assign eq   = res_q[1];
    assign lt   = res_q[0];

`ifdef LZX_CMP_CASCADE_CHECK_EN
    logic err_q, err_d;
    logic qa_onehot;

    always_comb begin
        qa_onehot = (qa == 3'b100) || (qa == 3'b010) || (qa == 3'b001);
        err_d     = err_q;
        if ((state_q == S_RUN) && !qa_onehot) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_lzx_cmp_cascade_ctrl.sv
// tb/tb_lzx_cmp_cascade_ctrl.sv - directed self-checking bench for lzx_cmp_cascade_ctrl with a 74HC85 behavioural model

module tb_lzx_cmp_cascade_ctrl;

    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

`ifdef LZX_CMP_CASCADE_CHECK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             gt, eq, lt;
    logic [3:0]       cmp_a, cmp_b;
    logic             ia_g, ia_e, ia_l;
    logic             qa_g, qa_e, qa_l;
    logic             err;
    logic             force_zero;
    logic [2:0]       qm;

    int n_checks = 0;
    int n_errors = 0;

    lzx_cmp_cascade_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .gt    (gt),
        .eq    (eq),
        .lt    (lt),
        .cmp_a (cmp_a),
        .cmp_b (cmp_b),
        .ia_g  (ia_g),
        .ia_e  (ia_e),
        .ia_l  (ia_l),
        .qa_g  (qa_g),
        .qa_e  (qa_e),
        .qa_l  (qa_l),
        .err   (err)
    );

    // One 74HC85: nibble magnitude decides, equal nibbles pass the cascade inputs through.
    always_comb begin
        qm = {ia_g, ia_e, ia_l};
        if (cmp_a > cmp_b)      qm = 3'b100;
        else if (cmp_a < cmp_b) qm = 3'b001;
        {qa_g, qa_e, qa_l} = force_zero ? 3'b000 : qm;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept a comparison, check nibble 0 presentation, latency, result and pulse width.
    task automatic run_cmp(input string tag, input logic [WIDTH-1:0] av,
                           input logic [WIDTH-1:0] bv, input logic [2:0] exp_res);
        int n;
        a = av;
        b = bv;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_cmp"}, {cmp_a, cmp_b, ia_g, ia_e, ia_l}, {av[3:0], bv[3:0], 3'b010});
        n = 0;
        while (!done && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_lat"}, n, NIB);
        chk({tag, "_res"}, {gt, eq, lt}, exp_res);
        chk({tag, "_idle"}, busy, 0);
        tick();
        chk({tag, "_pulse"}, {done, gt, eq, lt}, {1'b0, exp_res});
    endtask

    initial begin
        int n;
        int dcnt;
        int d0;
        int d1;
        int lt_ok;

        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        force_zero = 1'b0;
        tick();
        tick();
        chk("rst_out", {busy, done, gt, eq, lt, err}, 6'b0);
        chk("rst_cmp", {cmp_a, cmp_b}, 8'h00);
        chk("rst_ia", {ia_g, ia_e, ia_l}, 3'b010);
        rst_n = 1'b1;
        tick();
        tick();
        chk("idle_out", {busy, done, gt, eq, lt, err, ia_g, ia_e, ia_l}, 9'b000000010);

        run_cmp("lt_all", 16'h0000, 16'hFFFF, 3'b001);
        run_cmp("gt_msb", 16'h8000, 16'h7FFF, 3'b100);
        run_cmp("eq",     16'hA5A5, 16'hA5A5, 3'b010);
        run_cmp("gt_lsb", 16'h1235, 16'h1234, 3'b100);

        // start held high for 12 edges: done after E4 and E9
        a = 16'h00F0;
        b = 16'h0F00;
        start = 1'b1;
        dcnt = 0;
        d0 = -1;
        d1 = -1;
        lt_ok = 1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) begin
                if (dcnt == 0) d0 = i;
                if (dcnt == 1) d1 = i;
                dcnt++;
                if ({gt, eq, lt} !== 3'b001) lt_ok = 0;
            end
        end
        start = 1'b0;
        chk("b2b_cnt", dcnt, 2);
        chk("b2b_d0", d0, 4);
        chk("b2b_d1", d1, 9);
        chk("b2b_lt", lt_ok, 1);
        n = 0;
        while (busy && n < 20) begin
            tick();
            n++;
        end
        chk("b2b_drain", busy, 0);
        tick();

        // operands changed and start re-pulsed while busy must not disturb the result
        a = 16'h00F0;
        b = 16'h0F00;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        a = 16'hFFFF;
        b = 16'h0000;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!done && n < 20) begin
            tick();
            n++;
        end
        chk("relatch_done", done, 1);
        chk("relatch_res", {gt, eq, lt}, 3'b001);
        tick();
        chk("relatch_idle", {busy, done}, 2'b00);

        // cascade forced to 000 at the capture edge of nibble 1
        a = 16'h1000;
        b = 16'h0000;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        force_zero = 1'b1;
        tick();
        force_zero = 1'b0;
        n = 0;
        while (!done && n < 20) begin
            tick();
            n++;
        end
        chk("force_res", {gt, eq, lt}, 3'b100);
        chk("force_err", err, ERR_EXP);
        tick();
        run_cmp("after_err", 16'h0001, 16'h0002, 3'b001);
        chk("err_sticky", err, ERR_EXP);

        // reset at idx=2 aborts immediately
        a = 16'h0000;
        b = 16'h0001;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("abort_out", {busy, done, gt, eq, lt, err}, 6'b0);
        chk("abort_ia", {cmp_a, cmp_b, ia_g, ia_e, ia_l}, {8'h00, 3'b010});
        tick();
        rst_n = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done) dcnt++;
        end
        chk("abort_nodone", dcnt, 0);
        run_cmp("post_abort", 16'hFFFF, 16'hFFFE, 3'b100);
        chk("post_abort_err", err, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
